// File: rtl/noc_sw_pkg.sv
//------------------------------------------------------------------------------
// Module   : noc_sw_pkg
// Brief    : Shared defaults and state encoding for the VC switch allocator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package noc_sw_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_NUM_VC = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/vc_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : vc_rr_arbiter
// Brief    : Round-robin search: first requester at or after ptr, modulo N.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vc_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic             w_found_hi;
  logic [IDX_W-1:0] w_idx_hi;
  logic [IDX_W-1:0] w_idx_lo;

  // Downward scans leave the lowest hit: w_idx_hi among i >= ptr, w_idx_lo overall (wrap case).
  always_comb begin
    w_found_hi = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_idx_lo = IDX_W'(i);
        if (IDX_W'(i) >= ptr) begin
          w_idx_hi   = IDX_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
  end

  assign any       = |req;
  assign grant_idx = w_found_hi ? w_idx_hi : w_idx_lo;

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (grant_idx == IDX_W'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/vc_switch_alloc.sv
//------------------------------------------------------------------------------
// Module   : vc_switch_alloc
// Brief    : Packet-locked round-robin VC-to-output switch allocator with a
//            one-flit registered output stage. Optional packet counter is
//            enabled by defining VC_SWITCH_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vc_switch_alloc
  import noc_sw_pkg::*;
#(
  parameter int  DATA_W   = DEFAULT_DATA_W,
  parameter int  NUM_VC   = DEFAULT_NUM_VC,
  localparam int VC_IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic [NUM_VC-1:0]        vc_valid,
  input  logic [NUM_VC-1:0]        vc_head,
  input  logic [NUM_VC-1:0]        vc_tail,
  output logic [NUM_VC-1:0]        vc_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_head,
  output logic                     out_tail,
  output logic [VC_IDX_W-1:0]      out_vc,
  output logic                     locked
`ifdef VC_SWITCH_STATS_EN
  ,
  output logic [15:0]              pkt_cnt
`endif
);

  logic [0:0]          r_state;
  logic [VC_IDX_W-1:0] r_rr_ptr;
  logic [VC_IDX_W-1:0] r_owner;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_head;
  logic                r_out_tail;
  logic [VC_IDX_W-1:0] r_out_vc;

  logic                w_stage_free;
  logic [NUM_VC-1:0]   w_arb_grant;
  logic [VC_IDX_W-1:0] w_arb_idx;
  logic                w_arb_any;
  logic [NUM_VC-1:0]   w_own_oh;
  logic [NUM_VC-1:0]   w_gnt_oh;
  logic [VC_IDX_W-1:0] w_gnt_idx;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_head;
  logic                w_sel_tail;
  logic [VC_IDX_W-1:0] w_ptr_next;

  vc_rr_arbiter #(
    .N     (NUM_VC),
    .IDX_W (VC_IDX_W)
  ) u_arb (
    .req       (vc_valid & vc_head),
    .ptr       (r_rr_ptr),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx),
    .any       (w_arb_any)
  );

  assign w_stage_free = !r_out_valid || out_ready;
  assign w_own_oh     = {{(NUM_VC-1){1'b0}}, 1'b1} << r_owner;

  // While locked the owner keeps the output whatever the other VCs present.
  assign w_gnt_oh  = (r_state == ST_LOCKED) ? w_own_oh :
                     (w_arb_any ? w_arb_grant : '0);
  assign w_gnt_idx = (r_state == ST_LOCKED) ? r_owner : w_arb_idx;

  assign vc_ready = w_stage_free ? w_gnt_oh : '0;
  assign w_xfer   = |(vc_valid & vc_ready);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_data = vc_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_sel_head = |(vc_head & w_gnt_oh);
  assign w_sel_tail = |(vc_tail & w_gnt_oh);
  assign w_ptr_next = (w_gnt_idx == VC_IDX_W'(NUM_VC - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_head  <= 1'b0;
      r_out_tail  <= 1'b0;
      r_out_vc    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_head  <= w_sel_head;
        r_out_tail  <= w_sel_tail;
        r_out_vc    <= w_gnt_idx;
        if (r_state == ST_IDLE) begin
          r_rr_ptr <= w_ptr_next;
          if (!w_sel_tail) begin
            r_state <= ST_LOCKED;
            r_owner <= w_gnt_idx;
          end
        end else if (w_sel_tail) begin
          r_state <= ST_IDLE;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_head  = r_out_head;
  assign out_tail  = r_out_tail;
  assign out_vc    = r_out_vc;
  assign locked    = (r_state == ST_LOCKED);

`ifdef VC_SWITCH_STATS_EN
  logic [15:0] r_pkt_cnt;

  // Counts packets as their tail leaves the output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_tail) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_switch_alloc.sv
//------------------------------------------------------------------------------
// Module   : tb_vc_switch_alloc
// Brief    : Directed self-checking bench for vc_switch_alloc (NUM_VC=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vc_switch_alloc;

  logic         clk;
  logic         reset_n;
  logic [127:0] vc_data;
  logic [3:0]   vc_valid;
  logic [3:0]   vc_head;
  logic [3:0]   vc_tail;
  logic [3:0]   vc_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_head;
  logic         out_tail;
  logic [1:0]   out_vc;
  logic         locked;
`ifdef VC_SWITCH_STATS_EN
  logic [15:0]  pkt_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  vc_switch_alloc #(
    .DATA_W (32),
    .NUM_VC (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vc_data   (vc_data),
    .vc_valid  (vc_valid),
    .vc_head   (vc_head),
    .vc_tail   (vc_tail),
    .vc_ready  (vc_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_head  (out_head),
    .out_tail  (out_tail),
    .out_vc    (out_vc),
    .locked    (locked)
`ifdef VC_SWITCH_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_vc(input int i, input logic v, input logic h, input logic t,
                        input logic [31:0] d);
    vc_valid[i]        = v;
    vc_head[i]         = h;
    vc_tail[i]         = t;
    vc_data[i*32 +: 32] = d;
  endtask

  initial begin
    logic [3:0] e_rdy;
    clk       = 1'b0;
    reset_n   = 1'b0;
    vc_data   = '0;
    vc_valid  = '0;
    vc_head   = '0;
    vc_tail   = '0;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_vc", out_vc, 0);
    check("rst_locked", locked, 0);
    check("rst_out_head", out_head, 0);
    check("rst_out_tail", out_tail, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Continuous single-flit packets on every VC: 0,1,2,3,0 one per cycle.
    for (int i = 0; i < 4; i++) set_vc(i, 1'b1, 1'b1, 1'b1, 32'h100 + i);
    for (int k = 0; k < 5; k++) begin
      #1;
      e_rdy = 4'b0001 << (k % 4);
      check("rr_ready", vc_ready, e_rdy);
      tick();
      check("rr_out_vc", out_vc, k % 4);
      check("rr_out_data", out_data, 32'h100 + (k % 4));
      check("rr_out_valid", out_valid, 1);
      check("rr_out_ht", {out_head, out_tail}, 2'b11);
      check("rr_locked", locked, 0);
    end
    vc_valid = '0;
    tick();
    check("rr_drain", out_valid, 0);

    // Body flit on an unowned VC is ignored (rr_ptr = 1).
    set_vc(1, 1'b1, 1'b0, 1'b0, 32'h111);
    #1;
    check("body_ready", vc_ready, 4'b0000);
    tick();
    check("body_no_out", out_valid, 0);
    vc_valid = '0;

    // VC2 3-flit packet locks the output while VC0 waits with a head.
    set_vc(2, 1'b1, 1'b1, 1'b0, 32'h200);
    set_vc(0, 1'b1, 1'b1, 1'b1, 32'h0AA);
    #1;
    check("pkt_ready_head", vc_ready, 4'b0100);
    tick();
    check("pkt_vc_head", out_vc, 2);
    check("pkt_head_ht", {out_head, out_tail}, 2'b10);
    check("pkt_locked_1", locked, 1);
    set_vc(2, 1'b1, 1'b0, 1'b0, 32'h201);
    #1;
    check("pkt_ready_body", vc_ready, 4'b0100);
    tick();
    check("pkt_body_data", out_data, 32'h201);
    check("pkt_body_ht", {out_head, out_tail}, 2'b00);
    check("pkt_locked_2", locked, 1);
    set_vc(2, 1'b1, 1'b0, 1'b1, 32'h202);
    #1;
    check("pkt_ready_tail", vc_ready, 4'b0100);
    tick();
    check("pkt_tail_vc", out_vc, 2);
    check("pkt_tail_ht", {out_head, out_tail}, 2'b01);
    check("pkt_unlocked", locked, 0);
    set_vc(2, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("pkt_vc0_ready", vc_ready, 4'b0001);
    tick();
    check("pkt_vc0_out", out_vc, 0);
    check("pkt_vc0_data", out_data, 32'h0AA);
    vc_valid = '0;
    tick();
    check("pkt_drain", out_valid, 0);

    // Backpressure holds the output stage (rr_ptr = 1).
    out_ready = 1'b0;
    set_vc(1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    tick();
    check("bp_load_data", out_data, 32'hDEADBEEF);
    set_vc(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_vc(2, 1'b1, 1'b1, 1'b1, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", vc_ready, 4'b0000);
      check("bp_data", out_data, 32'hDEADBEEF);
      check("bp_valid_vc", {out_valid, out_vc}, 3'b101);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", vc_ready, 4'b0100);
    tick();
    check("bp_reload_data", out_data, 32'h12345678);
    check("bp_reload_vc", {out_valid, out_vc}, 3'b110);
    vc_valid = '0;
    tick();
    check("bp_drain", out_valid, 0);

    // Reset in the middle of a locked packet (rr_ptr = 3).
    set_vc(3, 1'b1, 1'b1, 1'b0, 32'h300);
    tick();
    check("lk_locked", locked, 1);
    check("lk_out_vc", out_vc, 3);
    set_vc(3, 1'b1, 1'b0, 1'b0, 32'h301);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_vc", out_vc, 0);
    check("mid_rst_locked", locked, 0);
    tick();
    reset_n = 1'b1;
    #1;
    check("post_rst_body_ready", vc_ready, 4'b0000);
    tick();
    check("post_rst_no_out", out_valid, 0);
    set_vc(3, 1'b1, 1'b1, 1'b1, 32'h3FF);
    set_vc(0, 1'b1, 1'b1, 1'b1, 32'h0FF);
    #1;
    check("post_rst_ready0", vc_ready, 4'b0001);
    tick();
    check("post_rst_vc0", out_vc, 0);
    #1;
    check("post_rst_ready3", vc_ready, 4'b1000);
    tick();
    check("post_rst_vc3", out_vc, 3);
    check("post_rst_data3", out_data, 32'h3FF);
    vc_valid = '0;
    tick();

`ifdef VC_SWITCH_STATS_EN
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    check("stats_rst", pkt_cnt, 0);
    tick();
    set_vc(0, 1'b1, 1'b1, 1'b1, 32'h55);
    for (int n = 0; n < 65537; n++) tick();
    vc_valid = '0;
    tick();
    check("stats_wrap", pkt_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
